// File: rtl/move_tick_scheduler_if.sv
// Handshake/status bundle between game_control, snake_control and move_tick_scheduler.
// The master side drives game status and acks; the slave side (the scheduler) drives move requests.
interface move_tick_scheduler_if;
    logic [1:0] status;
    logic [1:0] SW;
    logic [6:0] score;
    logic       frame_start;
    logic       move_ack;
    logic       pause_key;
    logic       move_req;
    logic [4:0] period;
    logic [2:0] level;
    logic       paused;
    logic       overrun;

    modport master (
        output status, SW, score, frame_start, move_ack, pause_key,
        input  move_req, period, level, paused, overrun
    );

    modport slave (
        input  status, SW, score, frame_start, move_ack, pause_key,
        output move_req, period, level, paused, overrun
    );
endinterface

// File: rtl/move_tick_scheduler.sv
// Frame-aligned snake step pacer: issues one move_req per game step, period shrinking with score.
// Define MOVE_PAUSE_EN to build in the pause_key toggle; without it paused is tied low.
module move_tick_scheduler #(
    parameter int BASE0       = 12,
    parameter int BASE1       = 8,
    parameter int BASE2       = 6,
    parameter int BASE3       = 4,
    parameter int MIN_PERIOD  = 2,
    parameter int LEVEL_SHIFT = 3,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    move_tick_scheduler_if.slave bus
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, COUNT, REQ} state_t;

    state_t        state;
    logic [4:0]    cnt;
    logic [TW-1:0] timer;
    logic [4:0]    base;
    logic [6:0]    score_lvl;
    logic [2:0]    level_next;
    logic [4:0]    period_next;
    logic          playing;
    logic          advance;

    assign playing   = (bus.status == 2'b01);
    assign score_lvl = bus.score >> LEVEL_SHIFT;

    // Candidate step length for the next interval; only sampled when COUNT is (re)entered.
    always_comb begin
        base = 5'(BASE0);
        case (bus.SW)
            2'b00:   base = 5'(BASE0);
            2'b01:   base = 5'(BASE1);
            2'b10:   base = 5'(BASE2);
            default: base = 5'(BASE3);
        endcase
        level_next = (score_lvl > 7'd7) ? 3'd7 : score_lvl[2:0];
        if ({1'b0, base} >= ({3'b000, level_next} + 6'(MIN_PERIOD)))
            period_next = base - {2'b00, level_next};
        else
            period_next = 5'(MIN_PERIOD);
    end

`ifdef MOVE_PAUSE_EN
    assign advance = bus.frame_start && !bus.paused;
`else
    logic unused_pause;
    assign advance      = bus.frame_start;
    assign unused_pause = bus.pause_key;
    assign bus.paused   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            timer        <= '0;
            bus.move_req <= 1'b0;
            bus.period   <= 5'(BASE0);
            bus.level    <= 3'd0;
            bus.overrun  <= 1'b0;
`ifdef MOVE_PAUSE_EN
            bus.paused   <= 1'b0;
`endif
        end else begin
`ifdef MOVE_PAUSE_EN
            if (!playing)
                bus.paused <= 1'b0;
            else if (bus.pause_key)
                bus.paused <= !bus.paused;
`endif
            if (!playing) begin
                state        <= IDLE;
                bus.move_req <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state       <= COUNT;
                        cnt         <= '0;
                        bus.period  <= period_next;
                        bus.level   <= level_next;
                        bus.overrun <= 1'b0;
                    end
                    COUNT: begin
                        if (advance) begin
                            if (cnt == bus.period - 5'd1) begin
                                state        <= REQ;
                                bus.move_req <= 1'b1;
                                timer        <= '0;
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                    end
                    REQ: begin
                        // A frame boundary passing with the request still pending means a missed step.
                        if (bus.frame_start)
                            bus.overrun <= 1'b1;
                        if (bus.move_ack) begin
                            state        <= COUNT;
                            bus.move_req <= 1'b0;
                            cnt          <= '0;
                            bus.period   <= period_next;
                            bus.level    <= level_next;
                        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                            state        <= COUNT;
                            bus.move_req <= 1'b0;
                            bus.overrun  <= 1'b1;
                            cnt          <= '0;
                            bus.period   <= period_next;
                            bus.level    <= level_next;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_move_tick_scheduler.sv
// Directed self-checking bench for move_tick_scheduler; expected values are hand-derived.
module tb_move_tick_scheduler;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    move_tick_scheduler_if bus ();

    move_tick_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [1:0] st, input logic [1:0] sw, input logic [6:0] sc);
        bus.status = st;
        bus.SW     = sw;
        bus.score  = sc;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic pulseFrame();
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic pulseAck();
        bus.move_ack = 1'b1;
        @(negedge clk);
        bus.move_ack = 1'b0;
    endtask

    task automatic pulsePause();
        bus.pause_key = 1'b1;
        @(negedge clk);
        bus.pause_key = 1'b0;
    endtask

    task automatic runFrames(input int n);
        for (int i = 0; i < n; i++) begin
            pulseFrame();
            tick(3);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        bus.frame_start = 1'b0;
        bus.move_ack    = 1'b0;
        bus.pause_key   = 1'b0;
        applyStimulus(2'b00, 2'b00, 7'd0);
        tick(3);
        checkOutput("rst_req",     8'(bus.move_req), 8'd0);
        checkOutput("rst_period",  8'(bus.period),   8'd12);
        checkOutput("rst_level",   8'(bus.level),    8'd0);
        checkOutput("rst_paused",  8'(bus.paused),   8'd0);
        checkOutput("rst_overrun", 8'(bus.overrun),  8'd0);
        rst_n = 1'b1;
        tick(1);

        $display("[TB] base period 12, ack 3 clk after request");
        applyStimulus(2'b01, 2'b00, 7'd0);
        tick(1);
        checkOutput("t1_period", 8'(bus.period), 8'd12);
        runFrames(11);
        checkOutput("t1_no_req_11", 8'(bus.move_req), 8'd0);
        pulseFrame();
        checkOutput("t1_req_12", 8'(bus.move_req), 8'd1);
        tick(2);
        pulseAck();
        checkOutput("t1_req_dropped", 8'(bus.move_req), 8'd0);
        runFrames(11);
        checkOutput("t1b_no_req_11", 8'(bus.move_req), 8'd0);
        pulseFrame();
        checkOutput("t1b_req_12", 8'(bus.move_req), 8'd1);
        applyStimulus(2'b01, 2'b01, 7'd0);
        tick(2);
        pulseAck();
        checkOutput("t3_period_8", 8'(bus.period), 8'd8);

        $display("[TB] score change mid-interval");
        runFrames(3);
        applyStimulus(2'b01, 2'b01, 7'd16);
        tick(1);
        checkOutput("t3_period_hold", 8'(bus.period), 8'd8);
        checkOutput("t3_level_hold",  8'(bus.level),  8'd0);
        runFrames(4);
        checkOutput("t3_no_req_7", 8'(bus.move_req), 8'd0);
        pulseFrame();
        checkOutput("t3_req_8", 8'(bus.move_req), 8'd1);
        tick(2);
        pulseAck();
        checkOutput("t3_period_6", 8'(bus.period), 8'd6);
        checkOutput("t3_level_2",  8'(bus.level),  8'd2);
        runFrames(5);
        checkOutput("t3_no_req_5", 8'(bus.move_req), 8'd0);
        pulseFrame();
        checkOutput("t3_req_6", 8'(bus.move_req), 8'd1);

        $display("[TB] floor and level saturation");
        applyStimulus(2'b01, 2'b11, 7'd40);
        tick(1);
        pulseAck();
        checkOutput("t2_level_5",  8'(bus.level),  8'd5);
        checkOutput("t2_period_2", 8'(bus.period), 8'd2);
        runFrames(1);
        checkOutput("t2_no_req_1", 8'(bus.move_req), 8'd0);
        pulseFrame();
        checkOutput("t2_req_2", 8'(bus.move_req), 8'd1);
        applyStimulus(2'b01, 2'b11, 7'd127);
        pulseAck();
        checkOutput("t2_level_7",   8'(bus.level),  8'd7);
        checkOutput("t2_period_2b", 8'(bus.period), 8'd2);

        $display("[TB] ack timeout");
        runFrames(1);
        pulseFrame();
        checkOutput("t4_req", 8'(bus.move_req), 8'd1);
        tick(63);
        checkOutput("t4_req_held_64",  8'(bus.move_req), 8'd1);
        checkOutput("t4_no_overrun_yet", 8'(bus.overrun), 8'd0);
        tick(1);
        checkOutput("t4_req_timeout", 8'(bus.move_req), 8'd0);
        checkOutput("t4_overrun",     8'(bus.overrun),  8'd1);
        runFrames(1);
        checkOutput("t4_no_req_1", 8'(bus.move_req), 8'd0);
        pulseFrame();
        checkOutput("t4_req_again", 8'(bus.move_req), 8'd1);

        $display("[TB] leave playing during request");
        applyStimulus(2'b10, 2'b11, 7'd127);
        tick(1);
        checkOutput("t5_req_drop",     8'(bus.move_req), 8'd0);
        checkOutput("t5_overrun_kept", 8'(bus.overrun),  8'd1);
        checkOutput("t5_period_kept",  8'(bus.period),   8'd2);
        applyStimulus(2'b01, 2'b11, 7'd127);
        tick(1);
        checkOutput("t5_overrun_clr", 8'(bus.overrun), 8'd0);
        pulseAck();
        checkOutput("t5_stray_ack", 8'(bus.move_req), 8'd0);

        $display("[TB] ack coincides with timeout");
        runFrames(1);
        pulseFrame();
        checkOutput("tie_req", 8'(bus.move_req), 8'd1);
        tick(63);
        pulseAck();
        checkOutput("tie_req_drop",   8'(bus.move_req), 8'd0);
        checkOutput("tie_no_overrun", 8'(bus.overrun),  8'd0);

        $display("[TB] frame while request pending");
        runFrames(1);
        pulseFrame();
        checkOutput("fr_req", 8'(bus.move_req), 8'd1);
        pulseFrame();
        checkOutput("fr_req_held", 8'(bus.move_req), 8'd1);
        checkOutput("fr_overrun",  8'(bus.overrun),  8'd1);
        pulseAck();
        checkOutput("fr_req_drop", 8'(bus.move_req), 8'd0);

        $display("[TB] pause handling");
        applyStimulus(2'b00, 2'b00, 7'd0);
        tick(1);
        applyStimulus(2'b01, 2'b00, 7'd0);
        tick(1);
        checkOutput("p_period_12", 8'(bus.period), 8'd12);
        runFrames(5);
        pulsePause();
`ifdef MOVE_PAUSE_EN
        checkOutput("p_paused", 8'(bus.paused), 8'd1);
        runFrames(30);
        checkOutput("p_frozen", 8'(bus.move_req), 8'd0);
        pulsePause();
        checkOutput("p_unpaused", 8'(bus.paused), 8'd0);
        runFrames(6);
        checkOutput("p_no_req_6", 8'(bus.move_req), 8'd0);
        pulseFrame();
        checkOutput("p_req_7", 8'(bus.move_req), 8'd1);
`else
        checkOutput("p_paused_tied", 8'(bus.paused), 8'd0);
        runFrames(6);
        checkOutput("p_no_req_11", 8'(bus.move_req), 8'd0);
        pulseFrame();
        checkOutput("p_req_12", 8'(bus.move_req), 8'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
